// File: rtl/v10_peak_finder.sv
// v10_peak_finder: threshold-triggered pulse peak detector capturing amplitude and timestamp
// Ports: clk, reset (async, active-high); filter_data, threshold (signed samples in);
//        peak_amp, peak_time, peak_valid (one-cycle strobe), pileup, busy (out).
// Option: define V10_PEAK_PILEUP_EN to defer the strobe to dead-time exit and flag pile-up.
module v10_peak_finder #(
    parameter int SIZE_FILTER_DATA = 16,
    parameter int TS_WIDTH = 16,
    parameter int DEAD_TIME = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    output logic signed [SIZE_FILTER_DATA-1:0] peak_amp,
    output logic [TS_WIDTH-1:0] peak_time,
    output logic peak_valid,
    output logic pileup,
    output logic busy
);
    localparam int CW = DEAD_TIME > 0 ? $clog2(DEAD_TIME + 1) : 1;
    typedef enum logic [1:0] {IDLE, ARMED, DEAD} state_t;
    state_t state;
    logic [TS_WIDTH-1:0] ts, ts_r, max_ts;
    logic signed [SIZE_FILTER_DATA-1:0] sample_r, max_v;
    logic [CW-1:0] cnt;
    logic above;
    assign above = sample_r > threshold;
`ifdef V10_PEAK_PILEUP_EN
    logic pile;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ts <= '0;
            ts_r <= '0;
            sample_r <= '0;
            max_v <= '0;
            max_ts <= '0;
            cnt <= '0;
            pile <= 1'b0;
            peak_amp <= '0;
            peak_time <= '0;
            peak_valid <= 1'b0;
            pileup <= 1'b0;
            busy <= 1'b0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
            ts_r <= ts;
            sample_r <= filter_data;
            peak_valid <= 1'b0;
            pileup <= 1'b0;
            case (state)
                IDLE: if (above) begin
                    state <= ARMED;
                    busy <= 1'b1;
                    max_v <= sample_r;
                    max_ts <= ts_r;
                end
                ARMED: if (!above) begin
                    state <= DEAD;
                    cnt <= CW'(DEAD_TIME);
                    pile <= 1'b0;
                end else if (sample_r > max_v) begin
                    max_v <= sample_r;
                    max_ts <= ts_r;
                end
                DEAD: if (cnt == '0) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    peak_valid <= 1'b1;
                    peak_amp <= max_v;
                    peak_time <= max_ts;
                    pileup <= pile | above;
                end else begin
                    cnt <= cnt - CW'(1);
                    if (above) pile <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
`else
    logic ended;
    assign pileup = 1'b0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ts <= '0;
            ts_r <= '0;
            sample_r <= '0;
            max_v <= '0;
            max_ts <= '0;
            cnt <= '0;
            ended <= 1'b0;
            peak_amp <= '0;
            peak_time <= '0;
            peak_valid <= 1'b0;
            busy <= 1'b0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
            ts_r <= ts;
            sample_r <= filter_data;
            // ended marks the ARMED->DEAD edge; the strobe follows one clock later
            ended <= state == ARMED && !above;
            peak_valid <= ended;
            if (ended) begin
                peak_amp <= max_v;
                peak_time <= max_ts;
            end
            case (state)
                IDLE: if (above) begin
                    state <= ARMED;
                    busy <= 1'b1;
                    max_v <= sample_r;
                    max_ts <= ts_r;
                end
                ARMED: if (!above) begin
                    state <= DEAD;
                    cnt <= CW'(DEAD_TIME);
                end else if (sample_r > max_v) begin
                    max_v <= sample_r;
                    max_ts <= ts_r;
                end
                DEAD: if (cnt == '0) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_v10_peak_finder.sv
// tb_v10_peak_finder: scoreboard bench for v10_peak_finder (16-bit and 4-bit timestamp instances)
module tb_v10_peak_finder;
    localparam int DT = 4;
`ifdef V10_PEAK_PILEUP_EN
    localparam int LAT = 3 + DT;
    localparam bit PU_EN = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit PU_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [15:0] filter_data = '0;
    logic signed [15:0] threshold = 16'sd100;
    logic signed [15:0] peak_amp, amp4;
    logic [15:0] peak_time;
    logic [3:0] time4;
    logic peak_valid, pileup, busy, valid4, pile4, busy4;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    typedef struct {int amp; int t; int due; bit pu;} exp_t;
    exp_t sb[$];
    exp_t e;

    v10_peak_finder #(.SIZE_FILTER_DATA(16), .TS_WIDTH(16), .DEAD_TIME(DT)) dut (
        .clk(clk), .reset(reset), .filter_data(filter_data), .threshold(threshold),
        .peak_amp(peak_amp), .peak_time(peak_time), .peak_valid(peak_valid),
        .pileup(pileup), .busy(busy));

    v10_peak_finder #(.SIZE_FILTER_DATA(16), .TS_WIDTH(4), .DEAD_TIME(DT)) dut4 (
        .clk(clk), .reset(reset), .filter_data(filter_data), .threshold(threshold),
        .peak_amp(amp4), .peak_time(time4), .peak_valid(valid4),
        .pileup(pile4), .busy(busy4));

    always #5 clk = ~clk;

    // cyc equals the timestamp the next rising edge will capture
    always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (!reset && peak_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe cyc=%0d got amp=%0d time=%0d", cyc, peak_amp, peak_time);
            end else begin
                e = sb.pop_front();
                total++;
                if (cyc !== e.due) begin
                    bad++;
                    $display("FAIL strobe_cycle got=%0d want=%0d", cyc, e.due);
                end
                total++;
                if (peak_amp !== 16'(e.amp)) begin
                    bad++;
                    $display("FAIL peak_amp got=%0d want=%0d", peak_amp, e.amp);
                end
                total++;
                if (peak_time !== 16'(e.t)) begin
                    bad++;
                    $display("FAIL peak_time got=%0d want=%0d", peak_time, e.t);
                end
                total++;
                if (pileup !== e.pu) begin
                    bad++;
                    $display("FAIL pileup got=%0b want=%0b", pileup, e.pu);
                end
                total++;
                if (time4 !== 4'(e.t) || amp4 !== 16'(e.amp) || valid4 !== 1'b1) begin
                    bad++;
                    $display("FAIL narrow_ts got time=%0d amp=%0d valid=%0b want time=%0d amp=%0d valid=1",
                             time4, amp4, valid4, e.t % 16, e.amp);
                end
            end
        end
    end

    task automatic send(input int v);
        filter_data = 16'(v);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        filter_data = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_peak(input int amp, input int t, input int end_ts, input bit pu);
        sb.push_back('{amp, t, end_ts + LAT, pu});
    endtask

    task automatic check_drained(input string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got=%0d want=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_busy(input string name, input logic want);
        total++;
        if (busy !== want) begin
            bad++;
            $display("FAIL %s_busy got=%0b want=%0b", name, busy, want);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (peak_amp !== 16'd0 || peak_time !== 16'd0) begin
            bad++;
            $display("FAIL reset_data got amp=%0d time=%0d want 0 0", peak_amp, peak_time);
        end
        total++;
        if ({peak_valid, pileup, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000", {peak_valid, pileup, busy});
        end
        total++;
        if ({amp4, time4, valid4, pile4, busy4} !== 23'd0) begin
            bad++;
            $display("FAIL reset_narrow got=%h want=0", {amp4, time4, valid4, pile4, busy4});
        end
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(0);
            check_busy("quiet", 1'b0);
        end
        check_drained("reset");
    endtask

    task automatic test_basic;
        do_reset();
        expect_peak(300, 3, 5, 1'b0);
        send(0); send(50); send(150); send(300); send(200);
        check_busy("armed", 1'b1);
        send(90);
        idle(5);
        check_busy("dead_last", 1'b1);
        idle(1);
        check_busy("back_idle", 1'b0);
        idle(8);
        total++;
        if (peak_amp !== 16'sd300 || peak_time !== 16'd3) begin
            bad++;
            $display("FAIL basic_hold got amp=%0d time=%0d want 300 3", peak_amp, peak_time);
        end
        check_drained("basic");
    endtask

    task automatic test_tie;
        do_reset();
        expect_peak(300, 1, 3, 1'b0);
        send(150); send(300); send(300); send(90);
        idle(12);
        check_drained("tie");
        send(100);
        for (int i = 0; i < 3; i++) begin
            send(0);
            check_busy("equal_thr", 1'b0);
        end
        send(-200);
        for (int i = 0; i < 3; i++) begin
            send(0);
            check_busy("negative", 1'b0);
        end
        total++;
        if (peak_amp !== 16'sd300 || peak_time !== 16'd1) begin
            bad++;
            $display("FAIL tie_hold got amp=%0d time=%0d want 300 1", peak_amp, peak_time);
        end
    endtask

    task automatic test_dead;
        do_reset();
        expect_peak(300, 3, 5, PU_EN);
        expect_peak(400, 12, 13, 1'b0);
        send(0); send(50); send(150); send(300); send(200); send(90);
        send(0); send(400);
        idle(4);
        send(400); send(0);
        idle(14);
        check_drained("dead");
    endtask

    task automatic test_pileup;
        do_reset();
        expect_peak(300, 3, 5, PU_EN);
        expect_peak(200, 14, 15, 1'b0);
        send(0); send(50); send(150); send(300); send(200); send(90);
        send(0); send(250);
        idle(6);
        send(200); send(0);
        idle(14);
        check_drained("pileup");
    endtask

    task automatic test_reset_armed;
        do_reset();
        send(0); send(0); send(150); send(300);
        check_busy("pre_abort", 1'b1);
        reset = 1'b1;
        #1;
        check_busy("async_abort", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        send(90);
        idle(15);
        check_busy("post_abort", 1'b0);
        total++;
        if (peak_amp !== 16'sd0 || peak_time !== 16'd0) begin
            bad++;
            $display("FAIL abort_data got amp=%0d time=%0d want 0 0", peak_amp, peak_time);
        end
        check_drained("abort");
    endtask

    task automatic test_wrap;
        do_reset();
        expect_peak(300, 17, 18, 1'b0);
        idle(16);
        send(150); send(300); send(90);
        idle(12);
        check_drained("wrap");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_dead();
        test_pileup();
        test_reset_armed();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
